// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage controller for an external asynchronous SRAM.
// Runs multi-cycle read/write strobe sequences, stalls the pipeline, and reports TLB misses.
module sram_ctrl #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        tlb_hit_i,
  input  logic        sram_ce_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        miss_o,
  output logic [31:0] badaddr_o,
  output logic [19:0] sram_addr_o,
  inout  wire  [31:0] sram_data_io,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic [3:0]  sram_be_n_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_WREC  = 3'd3,
    S_DONE  = 3'd4,
    S_MISS  = 3'd5
  } state_e;

  localparam logic [2:0] RD_LOAD = 3'(READ_WAIT - 1);
  localparam logic [2:0] WR_LOAD = 3'(WRITE_WAIT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] badaddr_q, badaddr_d;

  logic        ce_n_s, oe_n_s, we_n_s, bus_en_s, stall_s;
  logic [3:0]  be_n_s;
  logic        unused_s;

  // State and latched request fields; reset forces strobes inactive immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 20'd0;
      sel_q     <= 4'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      badaddr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      badaddr_q <= badaddr_d;
    end
  end

  // Next state, wait counter and request capture; inputs only sampled in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    badaddr_d = badaddr_q;
    case (state_q)
      S_IDLE: begin
        if (req_i && !tlb_hit_i) begin
          badaddr_d = addr_i;
          state_d   = S_MISS;
        end else if (req_i && sram_ce_i) begin
          addr_d  = addr_i[21:2];
          sel_d   = sel_i;
          wdata_d = data_i;
          if (we_i) begin
            state_d = S_WRITE;
            cnt_d   = WR_LOAD;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          rdata_d = sram_data_io;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 3'd0) begin
          state_d = S_WREC;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WREC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_MISS:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe, bus-enable and stall decode from the state register.
  always_comb begin
    ce_n_s   = 1'b1;
    oe_n_s   = 1'b1;
    we_n_s   = 1'b1;
    bus_en_s = 1'b0;
    be_n_s   = 4'hF;
    stall_s  = 1'b0;
    case (state_q)
      S_IDLE:  stall_s = req_i && (!tlb_hit_i || sram_ce_i);
      S_READ: begin
        ce_n_s  = 1'b0;
        oe_n_s  = 1'b0;
        be_n_s  = ~sel_q;
        stall_s = 1'b1;
      end
      S_WRITE: begin
        ce_n_s   = 1'b0;
        we_n_s   = 1'b0;
        bus_en_s = 1'b1;
        be_n_s   = ~sel_q;
        stall_s  = 1'b1;
      end
      // Data stays on the bus one cycle past WE rising for hold time.
      S_WREC: begin
        ce_n_s   = 1'b0;
        bus_en_s = 1'b1;
        be_n_s   = ~sel_q;
        stall_s  = 1'b1;
      end
      default: stall_s = 1'b0;
    endcase
  end

  assign sram_data_io = bus_en_s ? wdata_q : 32'hzzzz_zzzz;
  assign sram_addr_o  = addr_q;
  assign sram_ce_n_o  = ce_n_s;
  assign sram_oe_n_o  = oe_n_s;
  assign sram_we_n_o  = we_n_s;
  assign sram_be_n_o  = be_n_s;
  assign stall_o      = stall_s;
  assign ack_o        = (state_q == S_DONE);
  assign miss_o       = (state_q == S_MISS);
  assign data_o       = rdata_q;
  assign badaddr_o    = badaddr_q;
  assign unused_s     = ^{addr_i[31:22], addr_i[1:0]};

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

SRAM access controller sitting directly downstream of the TLB/address-decode stage in the MEM path. It takes a memory request from the MEM stage together with the translated physical address, `tlb_hit` and `sram_ce` from the TLB. When the target is SRAM, it runs a multi-cycle read or write on the external asynchronous SRAM and stalls the pipeline until the access completes. A request to an unmapped address raises a one-cycle TLB-miss pulse with the faulting address.

## Interface
Parameters:
- READ_WAIT, 2, cycles OE/CE held low before read data is sampled (legal 1..7)
- WRITE_WAIT, 2, cycles WE held low per write (legal 1..7)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_i  in  1  MEM-stage memory request; held by the requester until ack_o or miss_o
- we_i  in  1  1 = write, 0 = read
- sel_i  in  4  byte enables, active-high, bit n = byte lane n
- data_i  in  32  write data
- addr_i  in  32  physical address from the TLB (addr_o of the TLB stage)
- tlb_hit_i  in  1  TLB translation valid
- sram_ce_i  in  1  TLB decoded the target as SRAM
- data_o  out  32  read data, registered, valid when ack_o=1 for a read
- ack_o  out  1  one-cycle completion pulse
- stall_o  out  1  pipeline stall request
- miss_o  out  1  one-cycle TLB-miss exception pulse
- badaddr_o  out  32  faulting virtual/physical address latched on a miss
- sram_addr_o  out  20  SRAM word address = addr[21:2]
- sram_data_io  inout  32  SRAM data bus; hi-Z except while writing
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes
- sram_be_n_o  out  4  active-low byte enables = ~sel

## Operation
- States: IDLE, READ, WRITE, WREC, DONE, MISS. A 3-bit wait counter is loaded on entry to READ/WRITE.
- IDLE:
  - req_i=1, tlb_hit_i=0 -> latch badaddr_o=addr_i, go to MISS.
  - req_i=1, tlb_hit_i=1, sram_ce_i=1 -> latch addr[21:2], we, sel, data; go to READ (we_i=0) or WRITE (we_i=1).
  - req_i=1, tlb_hit_i=1, sram_ce_i=0 -> ignored (ROM/flash/serial owned elsewhere); stay IDLE, no stall, no ack.
- READ: ce_n=0, oe_n=0, we_n=1, bus hi-Z. Counter runs READ_WAIT cycles. In the last cycle, data_o <= sram_data_io; next state DONE.
- WRITE: ce_n=0, oe_n=1, we_n=0, bus driven with latched data. Counter runs WRITE_WAIT cycles; then WREC.
- WREC: one cycle with we_n=1, ce_n=0, data still driven (hold time); then DONE.
- DONE: ack_o=1, strobes inactive; next state IDLE.
- MISS: miss_o=1; next state IDLE. No SRAM strobe is asserted.
- SRAM strobes, be_n, sram_addr_o and bus enable are decoded from the state register and latched request fields only, never from live inputs. be_n stays 4'b1111 outside READ/WRITE/WREC.
- addr[1:0] and addr[31:22] are ignored for SRAM access.
- sel_i=0 on a write: the full cycle runs with be_n=4'b1111 (no byte written), then ack.
- If req_i drops mid-access, the access still completes and acks. Request inputs are not re-sampled until IDLE.
- req_i still high in the IDLE cycle after DONE is treated as a new request; each ack consumes exactly one request.

## Timing
- Reset values:
  - state IDLE
  - data_o=0, badaddr_o=0
  - ack_o=0, miss_o=0, stall_o=0
  - sram_ce_n_o=sram_oe_n_o=sram_we_n_o=1, sram_be_n_o=4'b1111, sram_addr_o=0, bus hi-Z
- Reset asserted mid-access: all strobes go inactive and the bus is released immediately (asynchronously); any pending ack is lost.
- stall_o, combinational:
  - 1 in IDLE when req_i && (!tlb_hit_i || sram_ce_i)
  - 1 in READ, WRITE, WREC
  - 0 in DONE, MISS, and otherwise
- Read latency: accept edge T0; READ occupies T0+1..T0+READ_WAIT; ack_o at cycle T0+READ_WAIT+1 (default 3 cycles after the accept cycle).
- Write latency: ack_o at cycle T0+WRITE_WAIT+2 (default 4).
- Miss latency: miss_o in the cycle after detection; badaddr_o is stable from that cycle until the next miss.
- Back-to-back: minimum request-to-request spacing is latency+1 (the IDLE cycle re-accepts).

## Test plan
- Reset with rst=0 mid-WRITE -> we_n/ce_n read 1 and bus is hi-Z within the same cycle; after release, state IDLE and all outputs at reset values.
- Read: addr_i=0x00001234, tlb_hit=1, sram_ce=1, sel=4'hF, SRAM model returns 0xDEADBEEF -> sram_addr_o=0x0048D, oe_n low 2 cycles, ack_o and data_o=0xDEADBEEF 3 cycles after accept, stall_o=1 for 3 cycles.
- Write: addr 0x00000010, data 0xA5A5_0F0F, sel=4'b0011 -> be_n=4'b1100, we_n low exactly 2 cycles, data held through WREC, ack at accept+4, SRAM word 4 low half = 0x0F0F.
- Miss: req with tlb_hit=0, addr 0x00400000 -> stall_o=1 in the detect cycle; next cycle miss_o=1 and badaddr_o=0x00400000; no SRAM strobe ever asserted.
- Non-SRAM target: tlb_hit=1, sram_ce=0 -> no stall, no ack, strobes idle for 10 cycles.
- Back-to-back: read then write held continuously on req_i -> two acks, second write starts in the IDLE cycle right after the first DONE; req_i dropped mid-read still yields one ack.
